// File: rtl/iq_path_arbiter.sv
// iq_path_arbiter
//   Two-requester round-robin arbiter that feeds one shared I/Q datapath.
//   The owner keeps the grant for a burst of up to BURST samples. It may
//   present at most one sample every GAP clocks. It loses the grant early
//   if it has nothing to offer when it is allowed to send.
//
// Ports
//   clk                  : clock, rising edge
//   reset                : asynchronous, active-high reset
//   req0_valid/req1_valid: requester offers a sample
//   req0_i/q, req1_i/q   : requester I/Q samples (two's complement, DW bits)
//   req0_ready/req1_ready: sample accepted this cycle when ready & valid
//   x_i, x_q             : registered sample into the shared datapath
//   x_valid              : one-cycle pulse, x_i/x_q hold a new sample
//   grant                : one-hot owner (bit0 req0, bit1 req1), 00 idle
//   busy                 : arbiter is serving a burst
module iq_path_arbiter #(
   parameter int DW    = 16,
   parameter int BURST = 8,
   parameter int GAP   = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0_valid,
   input  logic          req1_valid,
   input  logic [DW-1:0] req0_i,
   input  logic [DW-1:0] req0_q,
   input  logic [DW-1:0] req1_i,
   input  logic [DW-1:0] req1_q,
   output logic          req0_ready,
   output logic          req1_ready,
   output logic [DW-1:0] x_i,
   output logic [DW-1:0] x_q,
   output logic          x_valid,
   output logic [1:0]    grant,
   output logic          busy
);

   typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

   localparam logic [7:0] BURST_C   = 8'(BURST);
   localparam logic [3:0] PACE_LOAD = 4'(GAP - 1);

   state_t        state_q, state_d;
   logic [1:0]    grant_q, grant_d;
   logic          busy_q, busy_d;
   logic [DW-1:0] xi_q, xi_d;
   logic [DW-1:0] xq_q, xq_d;
   logic          xvalid_q, xvalid_d;
   logic [7:0]    burst_q, burst_d;
   logic [3:0]    pace_q, pace_d;
   // 1 = req1 was served last, 0 = req0 was served last
   logic          last_q, last_d;

   logic          owner_valid;
   logic          accept;

   // Ready depends only on registered state, so a requester sees it in the
   // same cycle it may present a sample.
   assign req0_ready  = (state_q == SERVE) && grant_q[0] && (pace_q == 4'd0);
   assign req1_ready  = (state_q == SERVE) && grant_q[1] && (pace_q == 4'd0);
   assign owner_valid = grant_q[0] ? req0_valid : req1_valid;
   assign accept      = (req0_ready && req0_valid) || (req1_ready && req1_valid);

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      busy_d   = busy_q;
      xi_d     = xi_q;
      xq_d     = xq_q;
      xvalid_d = 1'b0;
      burst_d  = burst_q;
      pace_d   = pace_q;
      last_d   = last_q;
      case (state_q)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               // req0 wins if it is alone, or if both are valid and req1 went last
               if (req0_valid && (!req1_valid || last_q)) grant_d = 2'b01;
               else                                       grant_d = 2'b10;
               burst_d = 8'd0;
               pace_d  = 4'd0;
               busy_d  = 1'b1;
               state_d = SERVE;
            end
         end
         SERVE: begin
            if (accept) begin
               xi_d     = grant_q[0] ? req0_i : req1_i;
               xq_d     = grant_q[0] ? req0_q : req1_q;
               xvalid_d = 1'b1;
               burst_d  = burst_q + 8'd1;
               pace_d   = PACE_LOAD;
               if (burst_q + 8'd1 == BURST_C) begin
                  state_d = IDLE;
                  grant_d = 2'b00;
                  busy_d  = 1'b0;
                  last_d  = grant_q[1];
               end
            end else if (pace_q != 4'd0) begin
               pace_d = pace_q - 4'd1;
            end else if (!owner_valid) begin
               // Owner was allowed to send but had nothing: give up the path
               state_d = IDLE;
               grant_d = 2'b00;
               busy_d  = 1'b0;
               last_d  = grant_q[1];
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         grant_q  <= 2'b00;
         busy_q   <= 1'b0;
         xi_q     <= '0;
         xq_q     <= '0;
         xvalid_q <= 1'b0;
         burst_q  <= 8'd0;
         pace_q   <= 4'd0;
         last_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         busy_q   <= busy_d;
         xi_q     <= xi_d;
         xq_q     <= xq_d;
         xvalid_q <= xvalid_d;
         burst_q  <= burst_d;
         pace_q   <= pace_d;
         last_q   <= last_d;
      end
   end

   assign x_i     = xi_q;
   assign x_q     = xq_q;
   assign x_valid = xvalid_q;
   assign grant   = grant_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_iq_path_arbiter.sv
module tb_iq_path_arbiter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Default-parameter instance
   logic        req0_valid, req1_valid;
   logic [15:0] req0_i, req0_q, req1_i, req1_q;
   logic        req0_ready, req1_ready;
   logic [15:0] x_i, x_q;
   logic        x_valid, busy;
   logic [1:0]  grant;

   // GAP=1, BURST=4 instance
   logic        b_req0_valid, b_req1_valid;
   logic [15:0] b_req0_i, b_req0_q, b_req1_i, b_req1_q;
   logic        b_req0_ready, b_req1_ready;
   logic [15:0] b_x_i, b_x_q;
   logic        b_x_valid, b_busy;
   logic [1:0]  b_grant;

   int n_assert = 0;
   int n_fail   = 0;
   int cnt [2];

   iq_path_arbiter #(.DW(16), .BURST(8), .GAP(2)) dut0 (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_i(req0_i), .req0_q(req0_q), .req1_i(req1_i), .req1_q(req1_q),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .x_i(x_i), .x_q(x_q), .x_valid(x_valid), .grant(grant), .busy(busy)
   );

   iq_path_arbiter #(.DW(16), .BURST(4), .GAP(1)) dut1 (
      .clk(clk), .reset(reset),
      .req0_valid(b_req0_valid), .req1_valid(b_req1_valid),
      .req0_i(b_req0_i), .req0_q(b_req0_q), .req1_i(b_req1_i), .req1_q(b_req1_q),
      .req0_ready(b_req0_ready), .req1_ready(b_req1_ready),
      .x_i(b_x_i), .x_q(b_x_q), .x_valid(b_x_valid), .grant(b_grant), .busy(b_busy)
   );

   function automatic logic [15:0] di(input int ow, input int c);
      return (ow == 0) ? 16'(c) : 16'(16'h0100 + c);
   endfunction

   function automatic logic [15:0] dq(input int ow, input int c);
      return ~di(ow, c);
   endfunction

   function automatic logic [1:0] onehot(input int ow);
      return (ow == 0) ? 2'b01 : 2'b10;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_data();
      req0_i = di(0, cnt[0]);
      req0_q = dq(0, cnt[0]);
      req1_i = di(1, cnt[1]);
      req1_q = dq(1, cnt[1]);
   endtask

   task automatic expect_a(input string tag, input logic [1:0] g, input logic b,
                           input logic xv, input logic r0, input logic r1);
      chk({tag, "/grant"}, 32'(grant), 32'(g));
      chk({tag, "/busy"}, 32'(busy), 32'(b));
      chk({tag, "/x_valid"}, 32'(x_valid), 32'(xv));
      chk({tag, "/ready0"}, 32'(req0_ready), 32'(r0));
      chk({tag, "/ready1"}, 32'(req1_ready), 32'(r1));
   endtask

   task automatic expect_b(input string tag, input logic [1:0] g, input logic b,
                           input logic xv, input logic r1);
      chk({tag, "/b_grant"}, 32'(b_grant), 32'(g));
      chk({tag, "/b_busy"}, 32'(b_busy), 32'(b));
      chk({tag, "/b_x_valid"}, 32'(b_x_valid), 32'(xv));
      chk({tag, "/b_ready1"}, 32'(b_req1_ready), 32'(r1));
      chk({tag, "/b_ready0"}, 32'(b_req0_ready), 32'(0));
   endtask

   // Owner ow is granted and ready; run n accepts at GAP=2 on dut0.
   // rel: the n-th accept is expected to end the burst.
   task automatic serve(input int ow, input int n, input bit rel);
      bit last;
      for (int k = 0; k < n; k++) begin
         last = rel && (k == n - 1);
         step();
         expect_a($sformatf("o%0d_acc%0d", ow, k), last ? 2'b00 : onehot(ow),
                  !last, 1'b1, 1'b0, 1'b0);
         chk($sformatf("o%0d_acc%0d/x_i", ow, k), 32'(x_i), 32'(di(ow, cnt[ow])));
         chk($sformatf("o%0d_acc%0d/x_q", ow, k), 32'(x_q), 32'(dq(ow, cnt[ow])));
         cnt[ow]++;
         drive_data();
         if (k != n - 1) begin
            step();
            expect_a($sformatf("o%0d_gap%0d", ow, k), onehot(ow), 1'b1, 1'b0,
                     ow == 0, ow == 1);
            chk($sformatf("o%0d_gap%0d/x_i_hold", ow, k), 32'(x_i), 32'(di(ow, cnt[ow] - 1)));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      cnt[0] = 0;
      cnt[1] = 0;
      reset = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drive_data();
      b_req0_valid = 1'b0;
      b_req1_valid = 1'b0;
      b_req0_i = 16'h0;
      b_req0_q = 16'h0;
      b_req1_i = 16'h0;
      b_req1_q = 16'h0;
      #1 reset = 1'b1;
      #1;
      // Reset state, before any clock edge
      expect_a("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset/x_i", 32'(x_i), 32'h0);
      chk("reset/x_q", 32'(x_q), 32'h0);
      expect_b("reset", 2'b00, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      reset = 1'b0;
      req0_valid = 1'b1;

      // Single requester: burst of 8, one idle clock, regrant
      step();
      expect_a("grant0", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
      serve(0, 8, 1'b1);
      step();
      expect_a("regrant0", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);

      // req1 valid during req0 SERVE is held off; reset after 5 accepts
      req1_valid = 1'b1;
      serve(0, 5, 1'b0);
      #2 reset = 1'b1;
      #1;
      expect_a("midreset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("midreset/x_i", 32'(x_i), 32'h0);
      chk("midreset/x_q", 32'(x_q), 32'h0);
      step();
      expect_a("inreset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // Both valid: req0 wins the tie after reset, then strict alternation
      step();
      expect_a("tie0", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
      serve(0, 8, 1'b1);
      step();
      expect_a("rr1", 2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
      serve(1, 8, 1'b1);
      step();
      expect_a("rr0", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);

      // Starvation: req0 stops after 3 accepts
      serve(0, 3, 1'b0);
      req0_valid = 1'b0;
      step();
      expect_a("starve_pace", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      expect_a("starve_rel", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      expect_a("starve_g1", 2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
      // full 8-sample burst proves the burst count restarted
      serve(1, 8, 1'b1);
      step();
      expect_a("solo_regrant1", 2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
      req1_valid = 1'b0;

      // GAP=1, BURST=4, req1 only: back-to-back accepts
      b_req1_valid = 1'b1;
      b_req1_i = 16'h0000;
      b_req1_q = 16'hFFF0;
      step();
      expect_b("b_grant", 2'b10, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         step();
         expect_b($sformatf("b_acc%0d", k), (k == 3) ? 2'b00 : 2'b10, k != 3, 1'b1, k != 3);
         chk($sformatf("b_acc%0d/x_q", k), 32'(b_x_q), 32'(16'hFFF0 + k));
         chk($sformatf("b_acc%0d/x_i", k), 32'(b_x_i), 32'(k));
         b_req1_i = 16'(k + 1);
         b_req1_q = 16'(16'hFFF0 + k + 1);
      end
      step();
      expect_b("b_regrant", 2'b10, 1'b1, 1'b0, 1'b1);
      chk("b_regrant/x_q_hold", 32'(b_x_q), 32'hFFF3);
      b_req1_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/iq_path_arbiter.md
IQ_PATH_ARBITER -- requirements
Module: iq_path_arbiter

Interface
REQ-001 SHALL have parameter DW, default 16: I and Q sample width in bits.
REQ-002 SHALL have parameter BURST, default 8: maximum samples accepted per grant, range 1..255.
REQ-003 SHALL have parameter GAP, default 2: minimum clocks between accepted samples, range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports req0_valid and req1_valid, inputs, 1 bit each: requester n offers a sample.
REQ-007 SHALL have ports req0_i, req0_q, req1_i and req1_q, inputs, DW bits each: requester I and Q samples, two's complement.
REQ-008 SHALL have ports req0_ready and req1_ready, outputs, 1 bit each: the sample is accepted this cycle when ready and valid are both 1.
REQ-009 SHALL have ports x_i and x_q, outputs, DW bits each: sample registered into the shared I/Q datapath.
REQ-010 SHALL have port x_valid, output, 1 bit: x_i and x_q carry a new sample this cycle.
REQ-011 SHALL have port grant, output, 2 bits: one-hot current owner; bit 0 is req0, bit 1 is req1, 00 when idle.
REQ-012 SHALL have port busy, output, 1 bit: the FSM is in the SERVE state.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and SERVE.
REQ-014 In IDLE, if any reqN_valid=1, the FSM SHALL pick one owner by round-robin, set grant, clear burst_cnt and pace_cnt, and enter SERVE on the next edge.
REQ-015 In round-robin, if both requesters are valid, the one not served last SHALL win; a sole valid requester SHALL always win.
REQ-016 Every ready output SHALL be 0 while in IDLE.
REQ-017 In SERVE, reqN_ready SHALL be combinational: grant[N] AND pace_cnt==0; the non-owner's ready SHALL be 0.
REQ-018 On accept, the block SHALL register x_i/x_q from the owner, pulse x_valid=1 for one clock (latency 1 cycle), increment burst_cnt, and load pace_cnt=GAP-1.
REQ-019 pace_cnt SHALL decrement by 1 per clock while nonzero, so the accept rate is at most 1 per GAP clocks; with GAP=1 the block SHALL accept back to back.
REQ-020 x_valid SHALL be 0 on every cycle without an accept; x_i and x_q SHALL hold their last value.
REQ-021 The block SHALL release to IDLE when the accept that makes burst_cnt==BURST occurs, clearing grant on the same edge.
REQ-022 The block SHALL also release to IDLE (starvation release) when pace_cnt==0 and the owner's valid=0.
REQ-023 The last-served pointer SHALL update to the owner on release.
REQ-024 A released requester SHALL re-arbitrate in IDLE (one idle clock minimum between grants); it SHALL win again only if the other requester is not valid.
REQ-025 A valid from the non-owner during SERVE SHALL be ignored until release; its sample SHALL NOT be dropped, because its ready stays 0.
REQ-026 burst_cnt SHALL be 8 bits wide and SHALL never exceed BURST.

Reset
REQ-027 While reset=1, asynchronously: FSM=IDLE, grant=00, busy=0, x_valid=0, x_i=x_q=0, burst_cnt=0, pace_cnt=0, ready outputs 0.
REQ-028 While reset=1, the last-served pointer SHALL be set to req1, so req0 has first priority after reset.
REQ-029 A reset asserted mid-burst SHALL discard the partial burst; no x_valid SHALL be emitted from in-flight state.
REQ-030 After reset deasserts, the first arbitration SHALL occur on the first clock edge with any valid=1.

Verification
REQ-031 Single requester, defaults: req0 valid constantly, samples 0,1,2,... -> grant=01; x_valid every 2nd clock; x_i=0..7; release after 8; 1 IDLE clock; regrant to req0.
REQ-032 Both valid from reset -> req0 bursts 8, then req1 bursts 8, then req0; at most 8 consecutive x_valid from one owner; no sample lost or duplicated.
REQ-033 Starvation: req0 drops valid after 3 accepts while req1 is valid -> req0 released; grant=10 after 1 IDLE clock; burst_cnt restarts at 0.
REQ-034 GAP=1, BURST=4, req1 only -> 4 consecutive x_valid pulses; x_q equals input with 1-clock latency.
REQ-035 Reset asserted after 5 accepts of a burst -> all outputs 0 within the same cycle (no clock edge needed); after deassertion, req0 wins the tie.
